// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling with a clock-derived bit timer.
// Emits one-cycle valid / frame_err strobes per frame.
module uart_rx_byte #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          sync1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic [7:0]    data_n;
  logic          valid_n;
  logic          ferr_n;

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= usb_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: frame-level timing model of expected strobes,
// data and busy, checked every cycle, plus directed literal checks.
module tb_uart_rx_byte;

  localparam int CR   = 1600000;
  localparam int BR   = 100000;
  localparam int MAXC = 40000;
  localparam int EXACT = 1600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       usb_rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(
    .CLOCK_RATE(CR),
    .BAUD_RATE (BR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .usb_rx   (usb_rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #50 clk = ~clk;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         chk_on = 1'b0;
  // expected event per cycle: 1 valid, 2 frame_err, 3 post-reset
  int         kind_a [MAXC];
  logic [7:0] byte_a [MAXC];
  bit         busy_a [MAXC];
  logic [7:0] mdata = 8'h00;
  int         got_t[$];
  logic [7:0] got_d[$];
  int         ferr_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_on && cyc < MAXC) begin
      if (kind_a[cyc] == 1) mdata = byte_a[cyc];
      else if (kind_a[cyc] == 3) mdata = 8'h00;
      check("valid", valid, kind_a[cyc] == 1);
      check("frame_err", frame_err, kind_a[cyc] == 2);
      check("busy", busy, busy_a[cyc]);
      check("data", data, mdata);
      if (valid === 1'b1) begin
        got_t.push_back(cyc);
        got_d.push_back(data);
      end
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  // Pin falls at the negedge of cycle c, so T0 = c+2 and the strobe
  // lands at T0+153. per is the sender bit period in 1/100 cycle.
  task automatic send(input logic [7:0] b, input bit ok, input int hold,
                      input int per, input int abort_at, output int c);
    logic [9:0] bits;
    time        t0;
    int         r;
    bits = {ok, b, 1'b0};
    c    = cyc;
    t0   = $time;
    if (abort_at >= 0) begin
      r = c + 16 * abort_at + 8;
      for (int t = c + 3; t <= r; t++) busy_a[t] = 1'b1;
      kind_a[r + 1] = 3;
    end else begin
      for (int t = c + 3; t <= (ok ? c + 154 : c + 162 + hold); t++)
        busy_a[t] = 1'b1;
      kind_a[c + 155] = ok ? 1 : 2;
      byte_a[c + 155] = b;
    end
    for (int k = 0; k < 10; k++) begin
      usb_rx = bits[k];
      if (k == abort_at) begin
        repeat (8) @(negedge clk);
        rst    = 1'b1;
        usb_rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (per == EXACT) repeat (16) @(negedge clk);
      else #(t0 + time'((k + 1) * per) - $time);
    end
    if (per != EXACT) @(negedge clk);
    if (!ok) begin
      repeat (hold) @(negedge clk);
      usb_rx = 1'b1;
    end
  endtask

  task automatic glitch(input int len);
    int c;
    c = cyc;
    for (int t = c + 3; t <= c + 10; t++) busy_a[t] = 1'b1;
    usb_rx = 1'b0;
    repeat (len) @(negedge clk);
    usb_rx = 1'b1;
    repeat (12 - len) @(negedge clk);
  endtask

  initial begin
    int c;
    int n0;
    int f0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_on = 1'b1;
    repeat (5) @(negedge clk);

    n0 = got_t.size();
    send(8'hA5, 1'b1, 0, EXACT, -1, c);
    repeat (4) @(negedge clk);
    check("a5_count", got_t.size() - n0, 1);
    if (got_t.size() > n0) begin
      check("a5_data", got_d[n0], 8'hA5);
      check("a5_latency", got_t[n0] - (c + 2), 153);
    end
    check("a5_ferr", ferr_cnt, 0);

    n0 = got_t.size();
    send(8'h00, 1'b1, 0, EXACT, -1, c);
    send(8'hFF, 1'b1, 0, EXACT, -1, c);
    send(8'h5A, 1'b1, 0, EXACT, -1, c);
    repeat (4) @(negedge clk);
    check("b2b_count", got_t.size() - n0, 3);
    if (got_t.size() >= n0 + 3) begin
      check("b2b_d0", got_d[n0], 8'h00);
      check("b2b_d1", got_d[n0 + 1], 8'hFF);
      check("b2b_d2", got_d[n0 + 2], 8'h5A);
    end
    check("b2b_ferr", ferr_cnt, 0);

    n0 = got_t.size();
    glitch(4);
    check("glitch_count", got_t.size() - n0, 0);
    check("glitch_data", data, 8'h5A);
    check("glitch_busy", busy, 0);

    f0 = ferr_cnt;
    send(8'h3C, 1'b0, 40, EXACT, -1, c);
    repeat (3) @(negedge clk);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_data", data, 8'h5A);
    send(8'h81, 1'b1, 0, EXACT, -1, c);
    repeat (4) @(negedge clk);
    check("after_ferr_data", data, 8'h81);

    n0 = got_t.size();
    send(8'hC3, 1'b1, 0, EXACT, 5, c);
    check("rst_data", data, 8'h00);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    send(8'h42, 1'b1, 0, EXACT, -1, c);
    repeat (4) @(negedge clk);
    check("rst_count", got_t.size() - n0, 1);
    check("rst_next_data", data, 8'h42);

    send(8'h96, 1'b1, 0, 1568, -1, c);
    repeat (4) @(negedge clk);
    check("fast_data", data, 8'h96);

    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        glitch($urandom_range(1, 6));
      end else if (sel == 1) begin
        send(8'($urandom_range(0, 255)), 1'b0, $urandom_range(0, 30),
             EXACT, -1, c);
        repeat ($urandom_range(2, 10)) @(negedge clk);
      end else begin
        send(8'($urandom_range(0, 255)), 1'b1, 0, EXACT, -1, c);
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial receiver for the host UART link: recovers 8N1 bytes from the `usb_rx` pin and presents each one as a parallel byte with a one-cycle valid strobe. It sits between the board's USB-serial bridge and the on-chip logic and is the receive-side counterpart of the design's UART transmit path. It runs entirely in the system clock domain and samples mid-bit, using a clock-derived bit timer.

## Interface
Parameters:
- `CLOCK_RATE`, default 100000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line bit rate in bit/s.
- Derived values:
  - `CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE` (integer division).
  - `HALF_BIT = CLKS_PER_BIT / 2`.
  - Counter width is `$clog2(CLKS_PER_BIT)`.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `usb_rx`  in  1: asynchronous serial line; idles high.
- `data`  out  8: last correctly framed byte, LSB = first data bit received.
- `valid`  out  1: one-cycle pulse when `data` updates.
- `frame_err`  out  1: one-cycle pulse when a stop bit samples low.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- `usb_rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rx_s`.
- States:
  - IDLE: bit counter = 0. On `rx_s == 0`, go to START.
  - START: count to `HALF_BIT-1`, then sample `rx_s`.
    - If 0, go to DATA; clear the bit counter and the bit index.
    - If 1, treat it as a glitch and return to IDLE with no strobes.
  - DATA: count to `CLKS_PER_BIT-1`, then sample `rx_s` into the shift register, LSB first. After index 7, go to STOP.
  - STOP: count to `CLKS_PER_BIT-1`, then sample `rx_s`.
    - If 1: load `data` from the shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s == 1`, then go to IDLE. This case covers breaks and line held low.
- `valid` and `frame_err` are never high in the same cycle, and each is high for exactly one cycle per frame.
- `data` holds its value between frames; it changes only in the cycle `valid` rises.
- Reset in any state:
  - Next state is IDLE.
  - `data`, `valid`, `frame_err`, `busy`, the counters and the shift register clear to 0.
  - Synchronizer flops go to 1.
  - A frame in progress is dropped silently.

## Timing
- T0 is the first cycle in which IDLE sees `rx_s == 0`. That is 2–3 clocks after the pin falls, due to the synchronizer.
- `busy` is high from T0+1.
- Sample points:
  - Start-bit sample at T0+`HALF_BIT`.
  - Data bit i (i = 0..7) sampled at T0+`HALF_BIT`+(i+1)·`CLKS_PER_BIT`.
  - Stop-bit sample at T0+`HALF_BIT`+9·`CLKS_PER_BIT`.
- `valid` or `frame_err` is registered: it is high in the cycle after the stop sample. `busy` falls in that same cycle.
- Back-to-back frames are supported.
  - The receiver is in IDLE half a bit before the next start edge.
  - There are no dead cycles beyond that.
- Tolerated baud mismatch is at least ±2% at `CLKS_PER_BIT` ≥ 16.

## Test plan
Use `CLOCK_RATE`=1600000 and `BAUD_RATE`=100000, so `CLKS_PER_BIT`=16 and `HALF_BIT`=8.
- Byte 0xA5 sent in clean 8N1 after reset → exactly one `valid` pulse; `data`=0xA5; `frame_err` never high. `valid` occurs 8+9·16+1 = 153 cycles after T0.
- Frames 0x00, 0xFF, 0x5A sent back to back with a 1-bit stop and no idle gap → three `valid` pulses with `data` 0x00, 0xFF, 0x5A in order, and no `frame_err`.
- A 4-cycle low glitch on `usb_rx` while idle → `busy` returns low after START; no `valid`, no `frame_err`; `data` unchanged.
- Byte 0x3C sent with its stop bit forced low, followed by the line held low for 40 cycles and then released → one `frame_err` pulse. `data` keeps the previous value, and `busy` stays high until 1–3 cycles after the line goes high. The next good byte 0x81 is then received correctly.
- `rst` asserted for one cycle during data bit 4 of byte 0xC3 → no strobe for that frame. All outputs are 0 in the cycle after reset. A following 0x42 gives `data`=0x42.
- Sender clocked 2% fast (period 15.68 cycles/bit) while sending 0x96 → `valid`, with `data`=0x96.
